// File: rtl/scs8hd_a2111oi_bist_ctrl.sv
// rtl/scs8hd_a2111oi_bist_ctrl.sv - BIST sequencer for one a2111oi cell under test
// Applies all 32 vectors, samples the cell after a settle delay and counts mismatches.
module scs8hd_a2111oi_bist_ctrl #(
  parameter int SETTLE_CYCLES = 0,
  parameter int ERRW          = 8
) (
  input  logic            CLK,
  input  logic            RESETB,
  input  logic            START,
  input  logic            ABORT,
  input  logic            Y_DUT,
  output logic            A1_DRV,
  output logic            A2_DRV,
  output logic            B1_DRV,
  output logic            C1_DRV,
  output logic            D1_DRV,
  output logic            BUSY,
  output logic            DONE,
  output logic            PASS,
  output logic [ERRW-1:0] ERR_CNT,
  output logic [4:0]      FIRST_FAIL
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_DONE} state_t;

  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [ERRW-1:0] ERR_MAX     = {ERRW{1'b1}};

  state_t          state, state_n;
  logic [4:0]      idx, idx_n;
  logic [3:0]      cnt, cnt_n;
  logic [4:0]      drv, drv_n;
  logic            busy, busy_n;
  logic            done, done_n;
  logic            pass, pass_n;
  logic [ERRW-1:0] err, err_n;
  logic [4:0]      ffail, ffail_n;

  logic            exp_y;
  logic            match;
  logic [ERRW-1:0] err_upd;

  // Vector map is idx = {D1,C1,B1,A2,A1}.
  assign exp_y = ~((idx[0] & idx[1]) | idx[2] | idx[3] | idx[4]);

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state <= ST_IDLE;
      idx   <= '0;
      cnt   <= '0;
      drv   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
      err   <= '0;
      ffail <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      drv   <= drv_n;
      busy  <= busy_n;
      done  <= done_n;
      pass  <= pass_n;
      err   <= err_n;
      ffail <= ffail_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    drv_n   = drv;
    busy_n  = busy;
    done_n  = 1'b0;
    pass_n  = pass;
    err_n   = err;
    ffail_n = ffail;
    err_upd = err;
    // An X or Z on Y_DUT fails the equality and is counted as a mismatch.
    match   = 1'b0;
    if (Y_DUT == exp_y) match = 1'b1;

    case (state)
      ST_IDLE: begin
        drv_n  = '0;
        busy_n = 1'b0;
        if (START && !ABORT) begin
          state_n = ST_SETTLE;
          idx_n   = '0;
          drv_n   = '0;
          cnt_n   = SETTLE_LOAD;
          busy_n  = 1'b1;
          err_n   = '0;
          ffail_n = '0;
          pass_n  = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (ABORT) begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
          drv_n   = '0;
          pass_n  = 1'b0;
        end else if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          if (!match) begin
            if (err != ERR_MAX) err_upd = err + 1'b1;
            if (err == '0) ffail_n = idx;
          end
          err_n = err_upd;
          if (idx != 5'd31) begin
            idx_n = idx + 5'd1;
            drv_n = idx + 5'd1;
            cnt_n = SETTLE_LOAD;
          end else begin
            state_n = ST_DONE;
            busy_n  = 1'b0;
            drv_n   = '0;
            done_n  = 1'b1;
            pass_n  = (err_upd == '0);
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        if (ABORT) pass_n = 1'b0;
      end
      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
        drv_n   = '0;
      end
    endcase
  end

  assign {D1_DRV, C1_DRV, B1_DRV, A2_DRV, A1_DRV} = drv;
  assign BUSY       = busy;
  assign DONE       = done;
  assign PASS       = pass;
  assign ERR_CNT    = err;
  assign FIRST_FAIL = ffail;

endmodule
